seq_phase_gen: RTL and testbench

SEQ_PHASE_GEN -- requirements
Module: seq_phase_gen

---
 rtl/seq_pkg.sv | 23 ++
 rtl/onehot_dec.sv | 17 +
 rtl/seq_phase_gen.sv | 123 ++++++++++++
 tb/tb_seq_phase_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the phase sequencer: FSM state encoding and the
// index-width helper used to size phase-index ports.
package seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bits needed to index n items; never less than one so a port stays legal.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary phase index to one-hot phase vector; all zeros while disabled.
module onehot_dec #(
  parameter int NPH = 6,
  parameter int IW  = 3
) (
  input  logic [IW-1:0]  idx,
  input  logic           en,
  output logic [NPH-1:0] onehot
);

  always_comb begin
    for (int k = 0; k < NPH; k++) begin
      onehot[k] = en && (idx == IW'(k));
    end
  end

endmodule

// File: rtl/seq_phase_gen.sv
// Phase sequencer: walks phases 0..LAST once or repeatedly, with stall,
// abort and a wrapping count of completed sequences.
module seq_phase_gen
  import seq_pkg::*;
#(
  parameter  int NPH = 6,
  parameter  int CW  = 8,
  localparam int IW  = clog2(NPH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           BGN,
  input  logic           END,
  input  logic           HOLD,
  input  logic           LOOP,
  input  logic [IW-1:0]  LAST,
  output logic [NPH-1:0] fi,
  output logic [IW-1:0]  PH_IDX,
  output logic           BUSY,
  output logic           DONE,
  output logic           ABORTED,
  output logic [CW-1:0]  SEQ_CNT
);

  localparam logic [IW-1:0] LAST_MAX = IW'(NPH - 1);
  localparam logic [IW:0]   NPH_X    = (IW + 1)'(NPH);

  state_e          state_q, state_d;
  logic [IW-1:0]   phase_q, phase_d;
  logic [IW-1:0]   last_q, last_d;
  logic            loop_q, loop_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    last_d    = last_q;
    loop_d    = loop_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (BGN && !END) begin
          state_d = ST_RUN;
          loop_d  = LOOP;
          last_d  = ({1'b0, LAST} >= NPH_X) ? LAST_MAX : LAST;
        end
      end
      ST_RUN: begin
        if (END) begin
          state_d   = ST_IDLE;
          phase_d   = '0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (!HOLD) begin
          if (phase_q == last_q) begin
            cnt_d = cnt_q + CW'(1);
            if (loop_q) begin
              phase_d = '0;
            end else begin
              state_d = ST_IDLE;
              phase_d = '0;
              done_d  = 1'b1;
            end
          end else begin
            phase_d = phase_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      last_q    <= LAST_MAX;
      loop_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // The index is forced to zero on every exit from RUN, so decoding it
  // gated by the run state yields a clean one-hot or all-zero vector.
  onehot_dec #(
    .NPH (NPH),
    .IW  (IW)
  ) u_dec (
    .idx    (phase_q),
    .en     (state_q == ST_RUN),
    .onehot (fi)
  );

  assign PH_IDX  = phase_q;
  assign BUSY    = (state_q == ST_RUN);
  assign DONE    = done_q;
  assign ABORTED = aborted_q;
  assign SEQ_CNT = cnt_q;

endmodule

// File: tb/tb_seq_phase_gen.sv
// Scoreboard bench for seq_phase_gen (NPH=6, CW=8): each scenario queues
// per-cycle stimulus with the expected registered outputs after that edge.
module tb_seq_phase_gen;

  logic       CLK;
  logic       RST;
  logic       BGN;
  logic       END;
  logic       HOLD;
  logic       LOOP;
  logic [2:0] LAST;
  logic [5:0] fi;
  logic [2:0] PH_IDX;
  logic       BUSY;
  logic       DONE;
  logic       ABORTED;
  logic [7:0] SEQ_CNT;

  seq_phase_gen #(
    .NPH (6),
    .CW  (8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BGN     (BGN),
    .END     (END),
    .HOLD    (HOLD),
    .LOOP    (LOOP),
    .LAST    (LAST),
    .fi      (fi),
    .PH_IDX  (PH_IDX),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ABORTED (ABORTED),
    .SEQ_CNT (SEQ_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       bgn;
    logic       en;
    logic       hold;
    logic       loop;
    logic [2:0] last;
  } stim_t;

  typedef struct packed {
    logic [5:0] fi;
    logic [2:0] ph;
    logic       busy;
    logic       done;
    logic       ab;
    logic [7:0] cnt;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_cmp;
  int    n_bad;
  int    exp_cnt;

  function automatic stim_t sv(input bit bgn, input bit en, input bit hold,
                               input bit loop, input int last);
    stim_t s;
    s.bgn  = bgn;
    s.en   = en;
    s.hold = hold;
    s.loop = loop;
    s.last = 3'(last);
    return s;
  endfunction

  function automatic exp_t e_run(input int ph, input int cnt);
    exp_t       e;
    logic [5:0] one;
    one    = 6'd1;
    e.fi   = one << ph;
    e.ph   = 3'(ph);
    e.busy = 1'b1;
    e.done = 1'b0;
    e.ab   = 1'b0;
    e.cnt  = 8'(cnt);
    return e;
  endfunction

  function automatic exp_t e_idle(input bit done, input bit ab, input int cnt);
    exp_t e;
    e.fi   = 6'd0;
    e.ph   = 3'd0;
    e.busy = 1'b0;
    e.done = done;
    e.ab   = ab;
    e.cnt  = 8'(cnt);
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.fi   = fi;
    o.ph   = PH_IDX;
    o.busy = BUSY;
    o.done = DONE;
    o.ab   = ABORTED;
    o.cnt  = SEQ_CNT;
    return o;
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    BGN  = s.bgn;
    END  = s.en;
    HOLD = s.hold;
    LOOP = s.loop;
    LAST = s.last;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t obs, ex;
    RST = 1'b0;
    apply(sv(0, 0, 0, 0, 0));
    #1;
    obs = observe();
    ex  = e_idle(0, 0, 0);
    n_cmp++;
    if (obs !== ex) begin
      n_bad++;
      $display("FAIL reset_async: got %p expected %p", obs, ex);
    end
    tick();
    tick();
    RST = 1'b1;
    tick();
    obs = observe();
    n_cmp++;
    if (obs !== ex) begin
      n_bad++;
      $display("FAIL reset_release: got %p expected %p", obs, ex);
    end
    exp_cnt = 0;
  endtask

  // LOOP/LAST/BGN wiggle mid-run must not disturb the latched single pass.
  task automatic test_single();
    exp_t obs, ex;
    int   k;
    for (int i = 0; i < 6; i++)
      push(sv(i == 0 || i == 2, 0, 0, i == 1, (i == 1) ? 1 : 5), e_run(i, exp_cnt));
    exp_cnt++;
    push(sv(0, 0, 0, 1, 1), e_idle(1, 0, exp_cnt));
    push(sv(0, 0, 0, 0, 5), e_idle(0, 0, exp_cnt));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      ex  = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL single step %0d: got %p expected %p", k, obs, ex);
      end
      k++;
    end
  endtask

  task automatic test_loop();
    exp_t obs, ex;
    int   base, k;
    base = exp_cnt;
    for (int i = 0; i < 10; i++)
      push(sv(i == 0, 0, 0, 1, 2), e_run(i % 3, base + i / 3));
    exp_cnt = base + 3;
    push(sv(0, 1, 0, 1, 2), e_idle(1, 1, exp_cnt));
    push(sv(0, 0, 0, 0, 5), e_idle(0, 0, exp_cnt));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      ex  = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL loop step %0d: got %p expected %p", k, obs, ex);
      end
      k++;
    end
  endtask

  task automatic test_hold_abort();
    exp_t obs, ex;
    int   k;
    push(sv(1, 0, 0, 0, 5), e_run(0, exp_cnt));
    push(sv(0, 0, 0, 0, 5), e_run(1, exp_cnt));
    push(sv(0, 0, 0, 0, 5), e_run(2, exp_cnt));
    for (int i = 0; i < 3; i++)
      push(sv(0, 0, 1, 0, 5), e_run(2, exp_cnt));
    push(sv(0, 0, 0, 0, 5), e_run(3, exp_cnt));
    push(sv(0, 1, 1, 0, 5), e_idle(1, 1, exp_cnt));
    push(sv(0, 0, 0, 0, 5), e_idle(0, 0, exp_cnt));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      ex  = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL hold_abort step %0d: got %p expected %p", k, obs, ex);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t obs, ex;
    int   k;
    push(sv(1, 0, 0, 0, 0), e_run(0, exp_cnt));
    exp_cnt++;
    push(sv(0, 0, 0, 0, 0), e_idle(1, 0, exp_cnt));
    push(sv(1, 0, 0, 0, 1), e_run(0, exp_cnt));
    push(sv(0, 0, 0, 0, 1), e_run(1, exp_cnt));
    exp_cnt++;
    push(sv(0, 0, 0, 0, 1), e_idle(1, 0, exp_cnt));
    push(sv(0, 0, 0, 0, 1), e_idle(0, 0, exp_cnt));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      ex  = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL back_to_back step %0d: got %p expected %p", k, obs, ex);
      end
      k++;
    end
  endtask

  task automatic test_clamp_conflict();
    exp_t obs, ex;
    int   k;
    push(sv(1, 1, 0, 0, 5), e_idle(0, 0, exp_cnt));
    push(sv(0, 0, 0, 0, 5), e_idle(0, 0, exp_cnt));
    for (int i = 0; i < 6; i++)
      push(sv(i == 0, 0, 0, 0, 7), e_run(i, exp_cnt));
    exp_cnt++;
    push(sv(0, 0, 0, 0, 7), e_idle(1, 0, exp_cnt));
    push(sv(0, 0, 0, 0, 7), e_idle(0, 0, exp_cnt));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      ex  = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL clamp_conflict step %0d: got %p expected %p", k, obs, ex);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t obs, ex;
    int   k;
    for (int i = 0; i < 5; i++)
      push(sv(i == 0, 0, 0, 1, 5), e_run(i, exp_cnt));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      ex  = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL reset_mid run step %0d: got %p expected %p", k, obs, ex);
      end
      k++;
    end
    RST = 1'b0;
    #1;
    exp_cnt = 0;
    ex  = e_idle(0, 0, 0);
    obs = observe();
    n_cmp++;
    if (obs !== ex) begin
      n_bad++;
      $display("FAIL reset_mid async: got %p expected %p", obs, ex);
    end
    tick();
    RST = 1'b1;
    push(sv(0, 0, 0, 0, 5), e_idle(0, 0, 0));
    push(sv(1, 0, 0, 0, 5), e_run(0, 0));
    push(sv(0, 0, 0, 0, 5), e_run(1, 0));
    push(sv(0, 1, 0, 0, 5), e_idle(1, 1, 0));
    push(sv(0, 0, 0, 0, 5), e_idle(0, 0, 0));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      tick();
      ex  = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== ex) begin
        n_bad++;
        $display("FAIL reset_mid restart step %0d: got %p expected %p", k, obs, ex);
      end
      k++;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = 0;
    test_reset();
    test_single();
    test_loop();
    test_hold_abort();
    test_back_to_back();
    test_clamp_conflict();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
